// File: rtl/if_id_queue_pkg.sv
// Shared widths, the queue entry payload and the empty-zero head select
// for the fetch-to-decode instruction queue.
package if_id_queue_pkg;

  localparam int unsigned WORD_LEN  = 32;
  localparam int unsigned IFQ_DEPTH = 4;

  // One fetched word as it travels from IF to ID.
  typedef struct packed {
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] instr;
  } ifq_entry_t;

  // Head select: pass the stored entry when valid, all zeros when empty.
  function automatic ifq_entry_t ifq_head_sel(input logic valid, input ifq_entry_t entry);
    return valid ? entry : '0;
  endfunction

endpackage

// File: rtl/if_queue_mem.sv
// Storage for the instruction queue: DEPTH entries, one synchronous write
// port and one asynchronous read port. Contents are not reset.
// Ports:
//   clk      rising-edge clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  entry to write
//   raddr_i  read address
//   rdata_o  entry at raddr_i (combinational)
module if_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ifq_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ifq_entry_t    rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-side instruction queue between IF and ID. Captures one
// {pc, instruction} pair every cycle IF is not frozen, freezes IF when full,
// presents the head to ID under a valid/stall handshake and discards all
// contents on a taken branch.
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   if_pc           PC driven by IF
//   if_instruction  instruction at if_pc
//   flush           taken-branch kill (IF's brTaken)
//   freeze          stall request to IF, high when full
//   id_stall        ID cannot accept the head this cycle
//   id_valid        head entry present
//   id_pc           PC of head entry (0 when empty)
//   id_instruction  instruction of head entry (0 when empty)
//   count           current occupancy, 0..DEPTH
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_LEN-1:0]      if_pc,
  input  logic [WORD_LEN-1:0]      if_instruction,
  input  logic                     flush,
  output logic                     freeze,
  input  logic                     id_stall,
  output logic                     id_valid,
  output logic [WORD_LEN-1:0]      id_pc,
  output logic [WORD_LEN-1:0]      id_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  ifq_entry_t       wr_entry;
  ifq_entry_t       head_raw;
  ifq_entry_t       head;

  // Status is decoded from registered occupancy only; no path from id_stall/flush.
  assign freeze   = (count_q == CNT_W'(DEPTH));
  assign id_valid = (count_q != '0);
  assign count    = count_q;

  // IF always presents a valid word, so every non-frozen, non-flushed cycle pushes.
  assign push = ~freeze & ~flush;
  assign pop  = id_valid & ~id_stall & ~flush;

  assign wr_entry.pc    = if_pc;
  assign wr_entry.instr = if_instruction;

  if_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_raw)
  );

  // Stale storage is never exposed: empty queue drives zeros to ID.
  assign head           = ifq_head_sel(id_valid, head_raw);
  assign id_pc          = head.pc;
  assign id_instruction = head.instr;

  // Pointer/occupancy next state; flush drops everything including this cycle's word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Occupancy can never exceed DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int unsigned DEPTH = IFQ_DEPTH;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [WORD_LEN-1:0] if_pc;
  logic [WORD_LEN-1:0] if_instruction;
  logic                flush;
  logic                freeze;
  logic                id_stall;
  logic                id_valid;
  logic [WORD_LEN-1:0] id_pc;
  logic [WORD_LEN-1:0] id_instruction;
  logic [CNT_W-1:0]    count;

  int n_vec = 0;
  int n_err = 0;

  // Bench-side IF PC and expected queue contents.
  logic [WORD_LEN-1:0] pc_m;
  ifq_entry_t          exp_q[$];

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .flush          (flush),
    .freeze         (freeze),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .count          (count)
  );

  function automatic logic [WORD_LEN-1:0] instr_of(input logic [WORD_LEN-1:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // One clock: drive inputs, compare head against scoreboard at negedge,
  // advance the model, land #1 after the edge.
  task automatic cycle(input logic r, input logic st, input logic fl,
                       input logic [WORD_LEN-1:0] tgt);
    ifq_entry_t e;
    ifq_entry_t h;
    bit         m_full;
    bit         m_push;
    bit         m_pop;
    rst            = r;
    id_stall       = st;
    flush          = fl;
    if_pc          = pc_m;
    if_instruction = instr_of(pc_m);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      if (id_valid !== 1'b1 || id_pc !== h.pc || id_instruction !== h.instr) begin
        n_err++;
        $display("FAIL head: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                 id_valid, id_pc, id_instruction, h.pc, h.instr);
      end
    end else begin
      if (id_valid !== 1'b0 || id_pc !== '0 || id_instruction !== '0) begin
        n_err++;
        $display("FAIL empty_head: valid=%b pc=%h instr=%h, required 0 0 0",
                 id_valid, id_pc, id_instruction);
      end
    end
    m_full = (exp_q.size() == DEPTH);
    m_push = !r && !fl && !m_full;
    m_pop  = !r && !fl && !st && (exp_q.size() != 0);
    if (r || fl) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        e.pc    = pc_m;
        e.instr = instr_of(pc_m);
        exp_q.push_back(e);
      end
    end
    if (r)            pc_m = '0;
    else if (fl)      pc_m = tgt;
    else if (!m_full) pc_m = pc_m + WORD_LEN'(4);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pc_m = '0;
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (count !== '0 || freeze !== 1'b0 || id_valid !== 1'b0 ||
        id_pc !== '0 || id_instruction !== '0) begin
      n_err++;
      $display("FAIL reset: count=%0d freeze=%b valid=%b pc=%h instr=%h, required all 0",
               count, freeze, id_valid, id_pc, id_instruction);
    end
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      n_vec++;
      if (count !== CNT_W'(1) || freeze !== 1'b0 || id_pc !== WORD_LEN'(4 * k)) begin
        n_err++;
        $display("FAIL free_run[%0d]: count=%0d freeze=%b pc=%h, required 1 0 %h",
                 k, count, freeze, id_pc, 4 * k);
      end
    end
  endtask

  task automatic test_stall_fill();
    int exp_cnt [6] = '{1, 2, 3, 4, 4, 4};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      n_vec++;
      if (count !== CNT_W'(exp_cnt[k]) || freeze !== (exp_cnt[k] == DEPTH) ||
          id_pc !== '0) begin
        n_err++;
        $display("FAIL stall_fill[%0d]: count=%0d freeze=%b pc=%h, required %0d %b 0",
                 k, count, freeze, id_pc, exp_cnt[k], exp_cnt[k] == DEPTH);
      end
    end
  endtask

  task automatic test_release();
    cycle(1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (count !== CNT_W'(3) || freeze !== 1'b0 || id_pc !== WORD_LEN'(4)) begin
      n_err++;
      $display("FAIL release_first: count=%0d freeze=%b pc=%h, required 3 0 4",
               count, freeze, id_pc);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      n_vec++;
      if (count !== CNT_W'(3) || freeze !== 1'b0) begin
        n_err++;
        $display("FAIL release[%0d]: count=%0d freeze=%b, required 3 0", k, count, freeze);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, WORD_LEN'(40));
    n_vec++;
    if (count !== '0 || id_valid !== 1'b0 || freeze !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clear: count=%0d valid=%b freeze=%b, required 0 0 0",
               count, id_valid, freeze);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== WORD_LEN'(40) || count !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL flush_target: valid=%b pc=%h count=%0d, required 1 28 1",
               id_valid, id_pc, count);
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_flush_full();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, '0);
    n_vec++;
    if (freeze !== 1'b1 || count !== CNT_W'(DEPTH)) begin
      n_err++;
      $display("FAIL full_before_flush: freeze=%b count=%0d, required 1 %0d",
               freeze, count, DEPTH);
    end
    cycle(1'b0, 1'b1, 1'b1, WORD_LEN'(100));
    n_vec++;
    if (count !== '0 || freeze !== 1'b0 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_full: count=%0d freeze=%b valid=%b, required 0 0 0",
               count, freeze, id_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (id_pc !== WORD_LEN'(100)) begin
      n_err++;
      $display("FAIL flush_full_target: pc=%h, required %h", id_pc, 100);
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_flush_wrap();
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, WORD_LEN'(200));
    n_vec++;
    if (count !== '0 || freeze !== 1'b0 || id_valid !== 1'b0 ||
        id_pc !== '0 || id_instruction !== '0) begin
      n_err++;
      $display("FAIL rst_and_flush: count=%0d freeze=%b valid=%b pc=%h instr=%h, required all 0",
               count, freeze, id_valid, id_pc, id_instruction);
    end
    for (int k = 0; k < 20; k++) cycle(1'b0, k[0], 1'b0, '0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (count !== CNT_W'(exp_q.size())) begin
      n_err++;
      $display("FAIL wrap_count: count=%0d, required %0d", count, exp_q.size());
    end
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    id_stall       = 1'b0;
    if_pc          = '0;
    if_instruction = '0;
    pc_m           = '0;
    test_reset();
    test_free_run();
    test_stall_fill();
    test_release();
    test_flush();
    test_flush_full();
    test_reset_flush_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
